spi_mem_responder: RTL



---
 rtl/spi_mem_responder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a small serial SRAM: READ (03), WRITE (02)
// and READ-ID (9F) over a byte array, with the bus oversampled by clk_in.
module spi_mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [23:0] JEDEC_ID = 24'h0D5D52
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic sclk_in,
  input  logic cs_n_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic miso_oe_out,
  output logic busy_out,
  output logic cmd_err_out
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic [7:0]  OP_READ  = 8'h03;
  localparam logic [7:0]  OP_WRITE = 8'h02;
  localparam logic [7:0]  OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, ID_DATA, IGNORE
  } state_t;

  state_t state, next_state;

  logic sclk_s1, sclk_s2, sclk_prev;
  logic cs_s1, cs_s2, cs_prev;
  logic mosi_s1, mosi_s2;
  logic [2:0] sync_fill;

  logic rise, fall, cs_on, cs_fall;

  logic [4:0]        bit_cnt;
  logic [6:0]        shift_in;
  logic [6:0]        shift_out;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        id_cnt;
  logic              load_pending;
  logic              is_write;

  logic [7:0] in_byte;
  logic [7:0] rd_byte;
  logic [7:0] mem [DEPTH];

  logic shift_cmd, cmd_done, bad_op;
  logic shift_addr, addr_done;
  logic shift_wr, wr_done;
  logic in_rd, load_byte, shift_rd;

  // sync_fill marks when every CS stage holds a real post-reset sample, so a
  // CS held low through reset is not mistaken for a fresh falling edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      sync_fill <= '0;
    end else begin
      sclk_s1   <= sclk_in;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      cs_s1     <= cs_n_in;
      cs_s2     <= cs_s1;
      cs_prev   <= cs_s2;
      mosi_s1   <= mosi_in;
      mosi_s2   <= mosi_s1;
      sync_fill <= {sync_fill[1:0], 1'b1};
    end
  end

  assign rise     = sclk_s2 & ~sclk_prev;
  assign fall     = ~sclk_s2 & sclk_prev;
  assign cs_on    = ~cs_s2;
  assign cs_fall  = sync_fill[2] & cs_prev & ~cs_s2;
  assign busy_out = cs_on;
  assign in_byte  = {shift_in, mosi_s2};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state != IDLE && !cs_on) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) next_state = CMD;
        CMD: begin
          if (cmd_done) begin
            case (in_byte)
              OP_READ, OP_WRITE: next_state = ADDR;
              OP_RDID:           next_state = ID_DATA;
              default:           next_state = IGNORE;
            endcase
          end
        end
        ADDR: if (addr_done) next_state = is_write ? WR_DATA : RD_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_cmd  = 1'b0;
    cmd_done   = 1'b0;
    bad_op     = 1'b0;
    shift_addr = 1'b0;
    addr_done  = 1'b0;
    shift_wr   = 1'b0;
    wr_done    = 1'b0;
    in_rd      = 1'b0;
    load_byte  = 1'b0;
    shift_rd   = 1'b0;
    if (cs_on) begin
      case (state)
        CMD: begin
          shift_cmd = rise;
          cmd_done  = rise && (bit_cnt == 5'd7);
          bad_op    = cmd_done && (in_byte != OP_READ) &&
                      (in_byte != OP_WRITE) && (in_byte != OP_RDID);
        end
        ADDR: begin
          shift_addr = rise;
          addr_done  = rise && (bit_cnt == 5'd23);
        end
        WR_DATA: begin
          shift_wr = rise;
          wr_done  = rise && (bit_cnt == 5'd7);
        end
        RD_DATA, ID_DATA: begin
          in_rd     = 1'b1;
          load_byte = load_pending || (fall && (bit_cnt == 5'd8));
          shift_rd  = !load_pending && fall && (bit_cnt != 5'd8);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_byte = mem[addr];
    if (state == ID_DATA) begin
      case (id_cnt)
        2'd0:    rd_byte = JEDEC_ID[23:16];
        2'd1:    rd_byte = JEDEC_ID[15:8];
        2'd2:    rd_byte = JEDEC_ID[7:0];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_done) mem[addr] <= in_byte;
  end

  // The first byte is presented early, so the falling edge that closes the
  // last address bit (bit_cnt==0) must only be counted, not shifted.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      id_cnt       <= '0;
      load_pending <= 1'b0;
      is_write     <= 1'b0;
      miso_out     <= 1'b0;
      miso_oe_out  <= 1'b0;
      cmd_err_out  <= 1'b0;
    end else begin
      cmd_err_out <= bad_op;
      if (!cs_on) begin
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        miso_out     <= 1'b0;
        miso_oe_out  <= 1'b0;
      end else begin
        if (state == IDLE && cs_fall) begin
          bit_cnt <= '0;
          addr    <= '0;
          id_cnt  <= '0;
        end
        if (shift_cmd) begin
          shift_in <= in_byte[6:0];
          bit_cnt  <= cmd_done ? 5'd0 : bit_cnt + 5'd1;
          if (cmd_done) begin
            is_write     <= (in_byte == OP_WRITE);
            load_pending <= (in_byte == OP_RDID);
          end
        end
        if (shift_addr) begin
          addr         <= {addr[ADDR_W-2:0], mosi_s2};
          bit_cnt      <= addr_done ? 5'd0 : bit_cnt + 5'd1;
          load_pending <= addr_done && !is_write;
        end
        if (shift_wr) begin
          shift_in <= in_byte[6:0];
          bit_cnt  <= wr_done ? 5'd0 : bit_cnt + 5'd1;
          if (wr_done) addr <= addr + ADDR_W'(1);
        end
        if (load_byte) begin
          shift_out    <= rd_byte[6:0];
          miso_out     <= rd_byte[7];
          miso_oe_out  <= 1'b1;
          load_pending <= 1'b0;
          bit_cnt      <= load_pending ? 5'd0 : 5'd1;
          if (state == ID_DATA) begin
            if (id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end else if (shift_rd) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt != 5'd0) begin
            miso_out  <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end
      end
    end
  end

  logic unused_in_rd;
  assign unused_in_rd = in_rd;

endmodule
